// File: rtl/t5_hart_sched_if.sv
// Fetch scheduler bus: configuration, suspend/wake, redirect inputs and issue outputs.
interface t5_hart_sched_if #(
    parameter int XLEN = 32
);
    logic            sena;
    logic [3:0]      hen;
    logic [3:0]      hsusp;
    logic [3:0]      hwake;
    logic            bvld;
    logic [1:0]      bhart;
    logic [XLEN-3:0] btgt;
    logic [XLEN-1:0] fpc;
    logic            fvld;
    logic [3:0]      hact;

    // Driver side: the pipeline / memory / execute stages feeding the scheduler.
    modport master (
        output sena, hen, hsusp, hwake, bvld, bhart, btgt,
        input  fpc, fvld, hact
    );

    // Scheduler side.
    modport slave (
        input  sena, hen, hsusp, hwake, bvld, bhart, btgt,
        output fpc, fvld, hact
    );
endinterface

// File: rtl/t5_hart_sched.sv
// Four-hart barrel fetch scheduler: per-hart PC and run state, round-robin
// issue of {word PC, hart ID}, redirects from execute, suspend/wake from memory.
module t5_hart_sched #(
    parameter int              XLEN  = 32,
    parameter logic [XLEN-1:0] RSTPC = '0
) (
    input  logic                sclk,
    input  logic                srst,
    t5_hart_sched_if.slave      bus
);
    localparam int PCW = XLEN - 2;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_SLEEP = 2'd2;

    logic [1:0]      state_q [4];
    logic [1:0]      state_d [4];
    logic [PCW-1:0]  pc_q    [4];
    logic [PCW-1:0]  pc_d    [4];
    logic [1:0]      rr_q, rr_d;
    logic [XLEN-1:0] fpc_q, fpc_d;
    logic            fvld_q, fvld_d;

    logic            hit;
    logic [1:0]      selHart;
    logic [1:0]      scanIdx;
    logic            issue;
    logic [PCW-1:0]  pcSel;
    logic [PCW-1:0]  pcInc;

    // Round-robin scan from the pointer for the first hart whose registered state is RUN.
    always_comb begin
        hit     = 1'b0;
        selHart = rr_q;
        scanIdx = rr_q;
        for (int k = 0; k < 4; k++) begin
            scanIdx = rr_q + 2'(k);
            if (!hit && state_q[scanIdx] == ST_RUN) begin
                hit     = 1'b1;
                selHart = scanIdx;
            end
        end
    end

    // Issue PC with same-cycle redirect bypass so a taken branch costs no bubble.
    always_comb begin
        issue = bus.sena && hit;
        if (bus.bvld && bus.bhart == selHart) begin
            pcSel = bus.btgt;
        end else begin
            pcSel = pc_q[selHart];
        end
        pcInc = pcSel + 1'b1;
    end

    // Per-hart run state: disable dominates, wake beats a simultaneous suspend.
    always_comb begin
        for (int h = 0; h < 4; h++) begin
            state_d[h] = state_q[h];
            if (!bus.hen[h]) begin
                state_d[h] = ST_IDLE;
            end else begin
                case (state_q[h])
                    ST_IDLE:  state_d[h] = ST_RUN;
                    ST_RUN:   if (!bus.hwake[h] && bus.hsusp[h]) state_d[h] = ST_SLEEP;
                    ST_SLEEP: if (bus.hwake[h]) state_d[h] = ST_RUN;
                    default:  state_d[h] = ST_IDLE;
                endcase
            end
        end
    end

    // Per-hart PC update: a redirect overrides the increment; an issued redirected hart lands on target+1.
    always_comb begin
        for (int h = 0; h < 4; h++) begin
            pc_d[h] = pc_q[h];
            if (issue && selHart == 2'(h)) begin
                pc_d[h] = pcInc;
            end else if (bus.bvld && bus.bhart == 2'(h)) begin
                pc_d[h] = bus.btgt;
            end
        end
    end

    // Registered issue decision; everything holds while the pipeline is stalled.
    always_comb begin
        fpc_d  = fpc_q;
        fvld_d = fvld_q;
        rr_d   = rr_q;
        if (bus.sena) begin
            fvld_d = hit;
            if (hit) begin
                fpc_d = {pcSel, selHart};
                rr_d  = selHart + 2'd1;
            end
        end
    end

    // State registers with synchronous reset discarding any pending requests.
    always_ff @(posedge sclk) begin
        if (srst) begin
            for (int h = 0; h < 4; h++) begin
                state_q[h] <= ST_IDLE;
                pc_q[h]    <= RSTPC[XLEN-1:2];
            end
            rr_q   <= 2'd0;
            fpc_q  <= '0;
            fvld_q <= 1'b0;
        end else begin
            for (int h = 0; h < 4; h++) begin
                state_q[h] <= state_d[h];
                pc_q[h]    <= pc_d[h];
            end
            rr_q   <= rr_d;
            fpc_q  <= fpc_d;
            fvld_q <= fvld_d;
        end
    end

    // Run status straight from the registered state.
    always_comb begin
        for (int h = 0; h < 4; h++) begin
            bus.hact[h] = (state_q[h] == ST_RUN);
        end
    end

    assign bus.fpc  = fpc_q;
    assign bus.fvld = fvld_q;
endmodule

// File: tb/tb_t5_hart_sched.sv
// Bench for the four-hart fetch scheduler: a behavioural reference model
// compared every cycle, plus directed literal checks pinning key values.
module tb_t5_hart_sched;
    localparam int XLEN = 32;
    localparam int RUNS = 1;
    localparam int IDLES = 0;
    localparam int SLEEPS = 2;

    logic sclk;
    logic srst;
    int   checks;
    int   errors;

    t5_hart_sched_if #(.XLEN(XLEN)) bus ();

    t5_hart_sched #(.XLEN(XLEN), .RSTPC(32'h0000_0000)) dut (
        .sclk (sclk),
        .srst (srst),
        .bus  (bus)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    // Reference model: hart run states, PCs, round-robin pointer, expected outputs.
    int          mState [4];
    logic [29:0] mPc    [4];
    int          mRr;
    logic [31:0] expFpc;
    logic        expFvld;
    logic [3:0]  expHact;
    logic        modelOn;

    initial modelOn = 1'b0;

    // Advance the model at every rising edge from the inputs the design also sees.
    always @(posedge sclk) begin
        int sel;
        logic [29:0] usePc;
        if (srst) begin
            for (int h = 0; h < 4; h++) begin
                mState[h] = IDLES;
                mPc[h]    = 30'h0;
            end
            mRr     = 0;
            expFpc  = 32'h0;
            expFvld = 1'b0;
            modelOn = 1'b1;
        end else if (modelOn) begin
            sel = -1;
            for (int off = 0; off < 4; off++) begin
                if (sel < 0 && mState[(mRr + off) % 4] == RUNS) sel = (mRr + off) % 4;
            end
            if (bus.bvld && !(bus.sena && sel == int'(bus.bhart))) mPc[bus.bhart] = bus.btgt;
            if (bus.sena) begin
                if (sel >= 0) begin
                    usePc   = (bus.bvld && int'(bus.bhart) == sel) ? bus.btgt : mPc[sel];
                    expFpc  = {usePc, 2'(sel)};
                    expFvld = 1'b1;
                    mPc[sel] = usePc + 30'd1;
                    mRr     = (sel + 1) % 4;
                end else begin
                    expFvld = 1'b0;
                end
            end
            for (int h = 0; h < 4; h++) begin
                if (!bus.hen[h]) mState[h] = IDLES;
                else if (mState[h] == IDLES) mState[h] = RUNS;
                else if (mState[h] == RUNS && bus.hsusp[h] && !bus.hwake[h]) mState[h] = SLEEPS;
                else if (mState[h] == SLEEPS && bus.hwake[h]) mState[h] = RUNS;
            end
        end
        for (int h = 0; h < 4; h++) expHact[h] = (mState[h] == RUNS);
    end

    // Every-cycle comparison of the design against the model.
    always @(negedge sclk) begin
        if (modelOn) begin
            checks++;
            if (bus.fvld !== expFvld || bus.hact !== expHact ||
                (expFvld && bus.fpc !== expFpc) || (!expFvld && $isunknown(bus.fpc))) begin
                errors++;
                $display("[TB] FAIL model t=%0t fpc=%h fvld=%b hact=%b expected fpc=%h fvld=%b hact=%b",
                         $time, bus.fpc, bus.fvld, bus.hact, expFpc, expFvld, expHact);
            end
        end
    end

    task automatic tick();
        @(negedge sclk);
    endtask

    task automatic applyStimulus(input logic sena, input logic [3:0] hen, input logic [3:0] hsusp,
                                 input logic [3:0] hwake, input logic bvld, input logic [1:0] bhart,
                                 input logic [29:0] btgt);
        bus.sena  = sena;
        bus.hen   = hen;
        bus.hsusp = hsusp;
        bus.hwake = hwake;
        bus.bvld  = bvld;
        bus.bhart = bhart;
        bus.btgt  = btgt;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] fpcExp, input logic fvldExp,
                               input logic [3:0] hactExp, input logic checkHact);
        checks++;
        if (bus.fvld !== fvldExp || bus.fpc !== fpcExp || (checkHact && bus.hact !== hactExp)) begin
            errors++;
            $display("[TB] FAIL %s got fpc=%h fvld=%b hact=%b want fpc=%h fvld=%b hact=%b",
                     name, bus.fpc, bus.fvld, bus.hact, fpcExp, fvldExp, hactExp);
        end
    endtask

    task automatic doReset();
        srst = 1'b1;
        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 30'h0);
        tick();
        tick();
        checkOutput("reset", 32'h0, 1'b0, 4'b0000, 1'b1);
        srst = 1'b0;
    endtask

    task automatic runIdle(input logic [3:0] hen, input int n);
        applyStimulus(1'b1, hen, 4'b0000, 4'b0000, 1'b0, 2'd0, 30'h0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        srst   = 1'b1;
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2'd0, 30'h0);
        tick();

        // Test 1: all harts, sequential PCs across harts.
        doReset();
        applyStimulus(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0, 30'h0);
        tick();
        checkOutput("t1_hact", 32'h0, 1'b0, 4'b1111, 1'b1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("t1_seq", 32'(i), 1'b1, 4'b1111, 1'b1);
        end

        // Test 2: harts 0 and 2 only.
        doReset();
        applyStimulus(1'b1, 4'b0101, 4'b0000, 4'b0000, 1'b0, 2'd0, 30'h0);
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("t2_seq", 32'(2 * i), 1'b1, 4'b0101, 1'b1);
        end

        // Test 3: suspend hart 2 as it is selected, wake it four cycles later.
        doReset();
        applyStimulus(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0, 30'h0);
        tick(); tick(); tick();
        bus.hsusp = 4'b0100;
        tick();
        checkOutput("t3_last_issue", 32'h2, 1'b1, 4'b1011, 1'b1);
        bus.hsusp = 4'b0000;
        tick();
        checkOutput("t3_skip_h3", 32'h3, 1'b1, 4'b1011, 1'b1);
        tick(); tick();
        bus.hwake = 4'b0100;
        tick();
        checkOutput("t3_wake_h3", 32'h7, 1'b1, 4'b1111, 1'b1);
        bus.hwake = 4'b0000;
        tick(); tick(); tick();
        checkOutput("t3_resume_h2", 32'h6, 1'b1, 4'b1111, 1'b1);

        // Test 4: same-cycle redirect of hart 1.
        doReset();
        applyStimulus(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b0, 2'd0, 30'h0);
        tick(); tick();
        applyStimulus(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd1, 30'h0000_0400);
        tick();
        checkOutput("t4_bypass", 32'h0000_1001, 1'b1, 4'b1111, 1'b1);
        bus.bvld = 1'b0;
        tick(); tick(); tick(); tick();
        checkOutput("t4_next_h1", 32'h0000_1005, 1'b1, 4'b1111, 1'b1);

        // Test 5: PC wrap at the top of the address space.
        doReset();
        applyStimulus(1'b1, 4'b0001, 4'b0000, 4'b0000, 1'b1, 2'd0, 30'h3FFF_FFFF);
        tick();
        bus.bvld = 1'b0;
        tick();
        checkOutput("t5_top", 32'hFFFF_FFFC, 1'b1, 4'b0001, 1'b1);
        tick();
        checkOutput("t5_wrap", 32'h0000_0000, 1'b1, 4'b0001, 1'b1);
        tick();
        checkOutput("t5_after", 32'h0000_0004, 1'b1, 4'b0001, 1'b1);

        // Test 6: stall, wake-beats-suspend, disable, then mid-stream reset.
        doReset();
        runIdle(4'b1111, 4);
        checkOutput("t6_pre", 32'h2, 1'b1, 4'b1111, 1'b1);
        bus.sena = 1'b0;
        bus.hsusp = 4'b0001;
        bus.hwake = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("t6_stall", 32'h2, 1'b1, 4'b1111, 1'b1);
            bus.hsusp = 4'b0000;
            bus.hwake = 4'b0000;
        end
        bus.sena = 1'b1;
        tick();
        checkOutput("t6_resume", 32'h3, 1'b1, 4'b1111, 1'b1);
        tick();
        checkOutput("t6_h0", 32'h4, 1'b1, 4'b1111, 1'b1);
        bus.hen = 4'b0000;
        tick();
        checkOutput("t6_hact_off", 32'h5, 1'b1, 4'b0000, 1'b1);
        tick();
        checkOutput("t6_fvld_off", 32'h5, 1'b0, 4'b0000, 1'b1);
        runIdle(4'b1111, 4);
        srst = 1'b1;
        applyStimulus(1'b1, 4'b1111, 4'b0000, 4'b0000, 1'b1, 2'd2, 30'h123);
        tick();
        checkOutput("t6_srst", 32'h0, 1'b0, 4'b0000, 1'b1);
        srst = 1'b0;
        bus.bvld = 1'b0;
        tick();
        tick();
        checkOutput("t6_rr_zero", 32'h0, 1'b1, 4'b1111, 1'b1);
        tick(); tick();
        checkOutput("t6_redirect_dropped", 32'h2, 1'b1, 4'b1111, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
